// File: rtl/seq_div_16x8.sv
// Iterative radix-2 restoring divider: 16-bit dividend by 8-bit divisor,
// one quotient bit per clock, valid/ready handshake on input and output.
module seq_div_16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [VW-1:0] prem;
  logic [VW-1:0] dvsr;
  logic [DW-1:0] shreg;
  logic [VW:0]   step;
  logic          last;

  // One restoring step: returns {quotient_bit, new_partial_remainder}.
  // The VW+1-bit trial value cannot overflow because prem < divisor.
  function automatic logic [VW:0] restore_step(input logic [VW-1:0] pr,
                                               input logic          msb,
                                               input logic [VW-1:0] d);
    logic [VW:0] t;
    logic [VW:0] res;
    t = {pr, msb};
    if (t >= {1'b0, d}) begin
      t   = t - {1'b0, d};
      res = {1'b1, t[VW-1:0]};
    end else begin
      res = {1'b0, t[VW-1:0]};
    end
    return res;
  endfunction

  assign step      = restore_step(prem, shreg[DW-1], dvsr);
  assign last      = (cnt == CW'(DW - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = (divisor == '0) ? DONE : CALC;
      CALC: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      prem        <= '0;
      dvsr        <= '0;
      shreg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvsr <= divisor;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[VW-1:0];
              div_by_zero <= 1'b1;
            end else begin
              prem        <= '0;
              shreg       <= dividend;
              cnt         <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          prem  <= step[VW-1:0];
          shreg <= {shreg[DW-2:0], step[VW]};
          cnt   <= cnt + CW'(1);
          // After the final step the shift register holds the full quotient.
          if (last) begin
            quotient  <= {shreg[DW-2:0], step[VW]};
            remainder <= step[VW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16x8.sv
// Scoreboard bench for seq_div_16x8: expected results are queued at
// acceptance and compared when out_valid appears.
module tb_seq_div_16x8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  seq_div_16x8 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    exp_t g;
    int   cyc;
    if (b == 8'd0) begin
      e.q = 16'hFFFF; e.r = a[7:0]; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / {8'd0, b}; e.r = 8'(a % {8'd0, b}); e.dz = 1'b0; e.lat = 17;
    end
    chk("in_ready_idle", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    g = sb.pop_front();
    chk("latency", cyc, g.lat);
    chk("quotient", quotient, g.q);
    chk("remainder", remainder, g.r);
    chk("div_by_zero", div_by_zero, g.dz);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_q", quotient, g.q);
      chk("hold_r", remainder, g.r);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'd1000, 8'd7, 0);
    run_op(16'hFFFF, 8'hFF, 0);
    run_op(16'hFFFF, 8'd1, 0);
    run_op(16'd5, 8'd200, 0);
    run_op(16'h1234, 8'd0, 0);
    run_op(16'd1000, 8'd7, 10);

    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ordy_valid", out_valid, 0);
    chk("idle_ordy_ready", in_ready, 1);
    out_ready = 1'b0;

    // Abort at the 8th CALC step.
    dividend = 16'd1000; divisor = 8'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_pulse", seen, 0);
    run_op(16'd100, 8'd10, 0);

    for (int k = 0; k < 8; k++) begin
      logic [15:0] ra;
      logic [7:0]  rb;
      ra = 16'($urandom);
      rb = (k == 5) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, k % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_div_16x8.md
Name: seq_div_16x8

Overview:
- Iterative radix-2 restoring divider; the inverse operation of the team's 8x8 multiplier.
- Takes a 16-bit dividend and an 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic test harness; used to recover operands from products and to check exact-vs-approximate product error.
- Valid/ready handshake on both input and output; one operation in flight at a time.

Parameters:
DW  16  dividend and quotient width
VW  8  divisor and remainder width

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  dividend/divisor valid
in_ready  output  1  block can accept an operation
dividend  input  DW  numerator, unsigned
divisor  input  VW  denominator, unsigned
out_valid  output  1  result valid, held until accepted
out_ready  input  1  consumer accepts result
quotient  output  DW  unsigned quotient
remainder  output  VW  unsigned remainder
div_by_zero  output  1  divisor was zero for the current result

Behaviour:
- Interface: one clock domain, clk; rst is synchronous and active-high.
- Reset: state IDLE.
  - in_ready=1, out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0.
  - Iteration counter=0 and partial remainder=0.
  - rst has priority over every other event. Asserting it mid-CALC or in DONE aborts the operation and discards the result; no out_valid pulse follows.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at a clock edge, the block captures dividend and divisor.
    - If divisor==0, go to DONE: quotient=all-ones (0xFFFF), remainder=dividend[VW-1:0], div_by_zero=1.
    - Otherwise go to CALC: partial remainder=0, shift register=dividend, counter=0, div_by_zero=0.
  - CALC: in_ready=0. Each edge performs one restoring step:
    - Form t = {partial_rem[VW-1:0], shift_msb} as VW+1 bits.
    - If t >= divisor: partial_rem = t - divisor and the shifted-in quotient bit is 1.
    - Otherwise: partial_rem = t and the quotient bit is 0.
    - The shift register shifts left by one, inserting the quotient bit at the LSB.
    - The counter increments. When the DW-th step completes (counter reaches DW-1 before the edge), go to DONE and load the quotient and remainder outputs.
  - DONE: out_valid=1, in_ready=0. Outputs stay stable while out_valid=1 && out_ready=0. On out_valid&&out_ready, go to IDLE, out_valid=0.
- Latency:
  - Nonzero divisor: out_valid rises DW+1 edges after the acceptance edge, i.e. 17 edges for DW=16.
  - Divisor zero: out_valid rises 1 edge after the acceptance edge.
  - Throughput: at most one operation per (latency+1) cycles. in_ready returns to 1 in the cycle after the output handshake.
- Arithmetic:
  - Invariant: dividend == quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
  - The VW+1-bit compare width means no overflow for any input, including divisor=0xFF.
- Boundaries:
  - in_valid is ignored while in_ready=0; the captured operands are not disturbed.
  - Input changes during CALC have no effect.
  - out_ready asserted while out_valid=0 has no effect.
  - Nothing from the output handshake cycle is registered into a new operation.
  - quotient, remainder and div_by_zero keep their last values in IDLE; their contents are undefined for consumers unless out_valid=1.

Test Plan:
- Basic: dividend=1000 (0x03E8), divisor=7 -> quotient=142 (0x008E), remainder=6, div_by_zero=0; out_valid rises exactly 17 edges after acceptance.
- Max operands: dividend=0xFFFF, divisor=0xFF -> quotient=257 (0x0101), remainder=0. Then dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0.
- Small dividend: dividend=5, divisor=200 -> quotient=0, remainder=5.
- Divide by zero: dividend=0x1234, divisor=0 -> out_valid after 1 edge, quotient=0xFFFF, remainder=0x34, div_by_zero=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid; outputs stay stable.
  - in_valid pulsed with new operands in this window is ignored; in_ready stays 0.
  - After out_ready=1 for one edge, in_ready=1 on the next cycle.
- Reset mid-operation: assert rst for one edge at the 8th CALC step of 1000/7 -> next cycle in_ready=1, out_valid=0, outputs zero; a following 100/10 returns quotient=10, remainder=0.
